// File: rtl/mem_port_ctrl.sv
// Purpose : valid/ready front end for the 14-bit RAM/ROM memory block; blocks ROM writes.
// Latency : write 1 cycle accept->rsp_valid, read 2 cycles (RAM and ROM alike).
// Backpr. : rsp_valid/data held until rsp_ready; req_ready only in IDLE, no overlap.
//
// Optional feature: MEM_PORT_BURST_EN enables read bursts of req_len_i+1 beats.
//
// Ports:
//   clk_i, rst_n_i        clock, async active-low reset
//   req_*_i / req_ready_o request channel (we, addr, wdata, len)
//   rsp_*_o / rsp_ready_i response channel (rdata, err, last)
//   mem_*_o / mem_outdata_i memory side (addr, indata, write, read strobes)
module mem_port_ctrl #(
   parameter int AW = 14,
   parameter int DW = 10,
   parameter int LW = 3
) (
   input  logic          clk_i,
   input  logic          rst_n_i,
   input  logic          req_valid_i,
   output logic          req_ready_o,
   input  logic          req_we_i,
   input  logic [AW-1:0] req_addr_i,
   input  logic [DW-1:0] req_wdata_i,
   input  logic [LW-1:0] req_len_i,
   output logic          rsp_valid_o,
   input  logic          rsp_ready_i,
   output logic [DW-1:0] rsp_rdata_o,
   output logic          rsp_err_o,
   output logic          rsp_last_o,
   output logic [AW-1:0] mem_addr_o,
   output logic [DW-1:0] mem_indata_o,
   output logic          mem_write_o,
   output logic          mem_read_o,
   input  logic [DW-1:0] mem_outdata_i
);

   typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_CAPT, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [AW-1:0] mem_addr_q, mem_addr_d;
   logic [DW-1:0] mem_indata_q, mem_indata_d;
   logic          mem_write_q, mem_write_d;
   logic          mem_read_q, mem_read_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [DW-1:0] rsp_rdata_q, rsp_rdata_d;
   logic          rsp_err_q, rsp_err_d;
   logic          rsp_last_q, rsp_last_d;
   logic          more_beats;

`ifdef MEM_PORT_BURST_EN
   logic [LW-1:0] cnt_q, cnt_d;
   logic [LW-1:0] len_q, len_d;
   logic [AW-1:0] addr_inc;

   // Writes always carry rsp_last=1, so a pending burst is exactly "not last".
   assign more_beats = ~rsp_last_q;
   assign addr_inc   = mem_addr_q + 1'b1;
`else
   logic unused_len;

   assign unused_len = ^req_len_i;
   assign more_beats = 1'b0;
`endif

   // State and registered outputs; reset drops the strobes without a clock edge.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q      <= S_IDLE;
         mem_addr_q   <= '0;
         mem_indata_q <= '0;
         mem_write_q  <= 1'b0;
         mem_read_q   <= 1'b0;
         rsp_valid_q  <= 1'b0;
         rsp_rdata_q  <= '0;
         rsp_err_q    <= 1'b0;
         rsp_last_q   <= 1'b0;
`ifdef MEM_PORT_BURST_EN
         cnt_q        <= '0;
         len_q        <= '0;
`endif
      end else begin
         state_q      <= state_d;
         mem_addr_q   <= mem_addr_d;
         mem_indata_q <= mem_indata_d;
         mem_write_q  <= mem_write_d;
         mem_read_q   <= mem_read_d;
         rsp_valid_q  <= rsp_valid_d;
         rsp_rdata_q  <= rsp_rdata_d;
         rsp_err_q    <= rsp_err_d;
         rsp_last_q   <= rsp_last_d;
`ifdef MEM_PORT_BURST_EN
         cnt_q        <= cnt_d;
         len_q        <= len_d;
`endif
      end
   end

   // Next-state logic.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (req_valid_i) state_d = req_we_i ? S_WR : S_RD;
         S_WR:    state_d = S_RESP;
         S_RD:    state_d = S_CAPT;
         S_CAPT:  state_d = S_RESP;
         S_RESP:  if (rsp_ready_i) state_d = more_beats ? S_RD : S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Output logic: next values of the registered outputs, plus req_ready.
   always_comb begin
      mem_addr_d   = mem_addr_q;
      mem_indata_d = mem_indata_q;
      mem_write_d  = 1'b0;
      mem_read_d   = 1'b0;
      rsp_valid_d  = rsp_valid_q;
      rsp_rdata_d  = rsp_rdata_q;
      rsp_err_d    = rsp_err_q;
      rsp_last_d   = rsp_last_q;
`ifdef MEM_PORT_BURST_EN
      cnt_d        = cnt_q;
      len_d        = len_q;
`endif
      case (state_q)
         S_IDLE: begin
            if (req_valid_i) begin
               // Strobes are raised on the accept edge so they cover exactly the
               // WR/RD cycle; ROM addresses never get a strobe.
               mem_addr_d   = req_addr_i;
               mem_indata_d = req_wdata_i;
               mem_write_d  = req_we_i & ~req_addr_i[AW-1];
               mem_read_d   = ~req_we_i & ~req_addr_i[AW-1];
`ifdef MEM_PORT_BURST_EN
               cnt_d        = '0;
               len_d        = req_len_i;
`endif
            end
         end
         S_WR: begin
            rsp_valid_d = 1'b1;
            rsp_rdata_d = '0;
            rsp_err_d   = mem_addr_q[AW-1];
            rsp_last_d  = 1'b1;
         end
         S_CAPT: begin
            // RAM: registered output of the RD-cycle read; ROM: combinational
            // data on the held address.
            rsp_valid_d = 1'b1;
            rsp_rdata_d = mem_outdata_i;
            rsp_err_d   = 1'b0;
`ifdef MEM_PORT_BURST_EN
            rsp_last_d  = (cnt_q == len_q);
`else
            rsp_last_d  = 1'b1;
`endif
         end
         S_RESP: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
`ifdef MEM_PORT_BURST_EN
               if (more_beats) begin
                  // Region is re-evaluated per beat, so bursts may cross into ROM.
                  mem_addr_d = addr_inc;
                  mem_read_d = ~addr_inc[AW-1];
                  cnt_d      = cnt_q + 1'b1;
               end
`endif
            end
         end
         default: ;
      endcase
   end

   assign req_ready_o  = (state_q == S_IDLE);
   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_rdata_o  = rsp_rdata_q;
   assign rsp_err_o    = rsp_err_q;
   assign rsp_last_o   = rsp_last_q;
   assign mem_addr_o   = mem_addr_q;
   assign mem_indata_o = mem_indata_q;
   assign mem_write_o  = mem_write_q;
   assign mem_read_o   = mem_read_q;

endmodule
